// File: rtl/spike_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | spike_collector : output spike FIFO, saturating class counters, argmax result    |
// | Revision 1.0                                                                      |
// +--------------------------------------------------------------------------------+
module spike_collector #(
  parameter int M          = 8,
  parameter int N_CLASS    = 10,
  parameter int CLASS_BASE = 246,
  parameter int CNT_W      = 8,
  parameter int CLS_W      = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             spike_pushback_i,
  input  logic [M-1:0]     spike_pushback_addr_i,
  input  logic             inference_done_i,
  input  logic             clear_i,
  input  logic             fifo_rd_ready_i,
  output logic             fifo_rd_valid_o,
  output logic [M-1:0]     fifo_rd_addr_o,
  output logic             fifo_overflow_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [CLS_W-1:0] result_class_o,
  output logic [CNT_W-1:0] result_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_SCAN    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [M:0]       C_BASE = (M+1)'(CLASS_BASE);
  localparam logic [M:0]       C_END  = (M+1)'(CLASS_BASE + N_CLASS);
  localparam logic [CLS_W-1:0] C_LAST = CLS_W'(N_CLASS - 1);
  localparam logic [PTR_W:0]   C_FULL = (PTR_W+1)'(FIFO_DEPTH);

  // Clear is a soft reset: both flush every piece of state.
  logic w_flush;
  assign w_flush = rst_i | clear_i;

  // ---------------- spike-address FIFO ----------------
  logic [M-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             ovf_q;
  logic             w_pop, w_full, w_push;

  assign w_pop  = (occ_q != '0) && fifo_rd_ready_i;
  assign w_full = (occ_q == C_FULL);
  assign w_push = spike_pushback_i && (!w_full || w_pop);

  always_comb begin
    occ_d = occ_q;
    if (w_push && !w_pop)      occ_d = occ_q + 1'b1;
    else if (w_pop && !w_push) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q <= occ_d;
      if (spike_pushback_i && !w_push) ovf_q <= 1'b1;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (!w_flush && w_push) mem_q[wr_ptr_q] <= spike_pushback_addr_i;
  end

  assign fifo_rd_valid_o = (occ_q != '0);
  assign fifo_rd_addr_o  = fifo_rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_overflow_o = ovf_q;

  // ---------------- class counters ----------------
  logic [1:0]             state_q, state_d;
  logic [M:0]             w_addr_ext;
  logic                   w_in_range, w_cnt_en;
  logic [CLS_W-1:0]       w_cls_idx;
  logic [N_CLASS*CNT_W-1:0] w_cnt_flat;

  assign w_addr_ext = {1'b0, spike_pushback_addr_i};
  assign w_in_range = (w_addr_ext >= C_BASE) && (w_addr_ext < C_END);
  assign w_cls_idx  = CLS_W'(spike_pushback_addr_i - C_BASE[M-1:0]);
  assign w_cnt_en   = (state_q == S_COLLECT) && spike_pushback_i && w_in_range;

  for (genvar k = 0; k < N_CLASS; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             w_hit;

    assign w_hit = w_cnt_en && (w_cls_idx == CLS_W'(k));

    always_ff @(posedge clk_i) begin
      if (w_flush)                  cnt_q <= '0;
      else if (w_hit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign w_cnt_flat[k*CNT_W +: CNT_W] = cnt_q;
  end

  // ---------------- argmax scan FSM ----------------
  logic [CLS_W-1:0] scan_idx_q, scan_idx_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [CNT_W-1:0] w_scan_cnt;

  always_comb begin
    w_scan_cnt = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (scan_idx_q == CLS_W'(k)) w_scan_cnt = w_cnt_flat[k*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_idx_d = scan_idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    case (state_q)
      S_COLLECT: begin
        if (inference_done_i) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties; index 0 seeds the best.
        if (scan_idx_q == '0 || w_scan_cnt > best_cnt_q) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = w_scan_cnt;
        end
        if (scan_idx_q == C_LAST) state_d = S_DONE;
        else                      scan_idx_d = scan_idx_q + 1'b1;
      end
      S_DONE:  ;
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_flush) begin
      state_q    <= S_COLLECT;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
    end
  end

  assign busy_o         = (state_q == S_SCAN);
  assign result_valid_o = (state_q == S_DONE);
  assign result_class_o = result_valid_o ? best_idx_q : '0;
  assign result_count_o = result_valid_o ? best_cnt_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_spike_collector.sv
`default_nettype none
// tb_spike_collector: directed scenarios plus randomized traffic against a queue/array reference model.
module tb_spike_collector;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       spike_pushback_i = 1'b0;
  logic [7:0] spike_pushback_addr_i = 8'd0;
  logic       inference_done_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       fifo_rd_ready_i = 1'b0;
  logic       fifo_rd_valid_o;
  logic [7:0] fifo_rd_addr_o;
  logic       fifo_overflow_o;
  logic       busy_o;
  logic       result_valid_o;
  logic [3:0] result_class_o;
  logic [7:0] result_count_o;

  int total = 0;
  int bad   = 0;

  spike_collector dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .spike_pushback_i      (spike_pushback_i),
    .spike_pushback_addr_i (spike_pushback_addr_i),
    .inference_done_i      (inference_done_i),
    .clear_i               (clear_i),
    .fifo_rd_ready_i       (fifo_rd_ready_i),
    .fifo_rd_valid_o       (fifo_rd_valid_o),
    .fifo_rd_addr_o        (fifo_rd_addr_o),
    .fifo_overflow_o       (fifo_overflow_o),
    .busy_o                (busy_o),
    .result_valid_o        (result_valid_o),
    .result_class_o        (result_class_o),
    .result_count_o        (result_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: FIFO as a queue, counters as ints, result computed by plain argmax.
  int mq[$];
  bit movf;
  int mcnt[10];
  int mphase;  // 0 collecting, 1 scanning, 2 result held
  int mleft;
  int mcls, mbest;

  task automatic model_step();
    bit pop, acc;
    int a;
    a = int'(spike_pushback_addr_i);
    if (rst_i || clear_i) begin
      mq.delete(); movf = 0; mphase = 0; mcls = 0; mbest = 0;
      foreach (mcnt[k]) mcnt[k] = 0;
      return;
    end
    pop = (mq.size() > 0) && fifo_rd_ready_i;
    acc = spike_pushback_i && ((mq.size() < 16) || pop);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back(a);
    if (spike_pushback_i && !acc) movf = 1;
    if (mphase == 0) begin
      if (spike_pushback_i && a >= 246 && a <= 255 && mcnt[a-246] < 255) mcnt[a-246]++;
      if (inference_done_i) begin mphase = 1; mleft = 10; end
    end else if (mphase == 1) begin
      mleft--;
      if (mleft == 0) begin
        mphase = 2; mcls = 0; mbest = mcnt[0];
        for (int k = 1; k < 10; k++) if (mcnt[k] > mbest) begin mcls = k; mbest = mcnt[k]; end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    spike_pushback_i = 0; inference_done_i = 0; clear_i = 0; fifo_rd_ready_i = 0; rst_i = 0;
  endtask

  task automatic do_clear();
    idle_inputs(); clear_i = 1; tick(); clear_i = 0;
  endtask

  task automatic spikes(input int addr, input int n);
    for (int i = 0; i < n; i++) begin
      spike_pushback_i = 1; spike_pushback_addr_i = 8'(addr); tick();
    end
    spike_pushback_i = 0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 20 && !result_valid_o; i++) tick();
  endtask

  task automatic test_reset();
    idle_inputs(); rst_i = 1; tick(); tick(); rst_i = 0;
    total++; if (fifo_rd_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fifo_rd_valid_o); end
    total++; if (fifo_rd_addr_o !== 8'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", fifo_rd_addr_o); end
    total++; if (fifo_overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", fifo_overflow_o); end
    total++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin bad++; $display("FAIL reset_busy_valid got=%b%b exp=00", busy_o, result_valid_o); end
    total++; if (result_class_o !== 4'd0 || result_count_o !== 8'd0) begin bad++; $display("FAIL reset_result got=%0d/%0d exp=0/0", result_class_o, result_count_o); end
  endtask

  task automatic test_basic();
    int exp_addr[9] = '{248, 248, 248, 250, 250, 250, 250, 250, 12};
    do_clear();
    spikes(248, 3); spikes(250, 5); spikes(12, 1);
    inference_done_i = 1; tick(); inference_done_i = 0;
    for (int i = 0; i < 10; i++) begin
      total++; if (busy_o !== 1'b1 || result_valid_o !== 1'b0) begin bad++; $display("FAIL basic_busy cyc=%0d got=%b%b exp=10", i, busy_o, result_valid_o); end
      tick();
    end
    total++; if (busy_o !== 1'b0 || result_valid_o !== 1'b1) begin bad++; $display("FAIL basic_done got=%b%b exp=01", busy_o, result_valid_o); end
    total++; if (result_class_o !== 4'd4 || result_count_o !== 8'd5) begin bad++; $display("FAIL basic_result got=%0d/%0d exp=4/5", result_class_o, result_count_o); end
    fifo_rd_ready_i = 1;
    for (int i = 0; i < 9; i++) begin
      total++; if (fifo_rd_valid_o !== 1'b1 || fifo_rd_addr_o !== 8'(exp_addr[i])) begin bad++; $display("FAIL basic_pop idx=%0d got=%b/%0d exp=1/%0d", i, fifo_rd_valid_o, fifo_rd_addr_o, exp_addr[i]); end
      tick();
    end
    fifo_rd_ready_i = 0;
    total++; if (fifo_rd_valid_o !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", fifo_rd_valid_o); end
    total++; if (result_valid_o !== 1'b1 || result_class_o !== 4'd4) begin bad++; $display("FAIL basic_hold got=%b/%0d exp=1/4", result_valid_o, result_class_o); end
  endtask

  task automatic test_tie();
    do_clear(); fifo_rd_ready_i = 1;
    spikes(246, 2); spikes(249, 2);
    inference_done_i = 1; tick(); inference_done_i = 0;
    wait_result();
    total++; if (result_valid_o !== 1'b1 || result_class_o !== 4'd0 || result_count_o !== 8'd2) begin bad++; $display("FAIL tie got=%b/%0d/%0d exp=1/0/2", result_valid_o, result_class_o, result_count_o); end
  endtask

  task automatic test_saturate();
    do_clear(); fifo_rd_ready_i = 1;
    spikes(255, 300);
    inference_done_i = 1; tick(); inference_done_i = 0;
    wait_result();
    total++; if (result_valid_o !== 1'b1 || result_class_o !== 4'd9 || result_count_o !== 8'd255) begin bad++; $display("FAIL saturate got=%b/%0d/%0d exp=1/9/255", result_valid_o, result_class_o, result_count_o); end
    total++; if (fifo_overflow_o !== 1'b0) begin bad++; $display("FAIL saturate_ovf got=%b exp=0", fifo_overflow_o); end
  endtask

  task automatic test_overflow_clear();
    do_clear();
    for (int k = 0; k < 20; k++) spikes((246 + k) % 256, 1);
    total++; if (fifo_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", fifo_overflow_o); end
    fifo_rd_ready_i = 1;
    for (int k = 0; k < 16; k++) begin
      total++; if (fifo_rd_valid_o !== 1'b1 || fifo_rd_addr_o !== 8'((246 + k) % 256)) begin bad++; $display("FAIL ovf_pop idx=%0d got=%b/%0d exp=1/%0d", k, fifo_rd_valid_o, fifo_rd_addr_o, (246 + k) % 256); end
      tick();
    end
    fifo_rd_ready_i = 0;
    total++; if (fifo_rd_valid_o !== 1'b0 || fifo_overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%b/%b exp=0/1", fifo_rd_valid_o, fifo_overflow_o); end
    spikes(250, 2);
    do_clear();
    total++; if (fifo_rd_valid_o !== 1'b0 || fifo_overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b/%b exp=0/0", fifo_rd_valid_o, fifo_overflow_o); end
    inference_done_i = 1; tick(); inference_done_i = 0;
    wait_result();
    total++; if (result_valid_o !== 1'b1 || result_class_o !== 4'd0 || result_count_o !== 8'd0) begin bad++; $display("FAIL zero_counters got=%b/%0d/%0d exp=1/0/0", result_valid_o, result_class_o, result_count_o); end
  endtask

  task automatic test_full_pushpop();
    int popped;
    int last;
    do_clear();
    for (int k = 1; k <= 16; k++) spikes(k, 1);
    spike_pushback_i = 1; spike_pushback_addr_i = 8'd100; fifo_rd_ready_i = 1; tick();
    spike_pushback_i = 0; fifo_rd_ready_i = 0;
    total++; if (fifo_overflow_o !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b exp=0", fifo_overflow_o); end
    total++; if (fifo_rd_addr_o !== 8'd2) begin bad++; $display("FAIL full_pushpop_head got=%0d exp=2", fifo_rd_addr_o); end
    popped = 0; last = -1; fifo_rd_ready_i = 1;
    for (int i = 0; i < 20 && fifo_rd_valid_o; i++) begin last = int'(fifo_rd_addr_o); popped++; tick(); end
    fifo_rd_ready_i = 0;
    total++; if (popped != 16 || last != 100) begin bad++; $display("FAIL full_pushpop_occ got=%0d/%0d exp=16/100", popped, last); end
  endtask

  task automatic test_done_scan_spike();
    do_clear(); fifo_rd_ready_i = 0;
    spike_pushback_i = 1; spike_pushback_addr_i = 8'd247; inference_done_i = 1; tick();
    inference_done_i = 0; tick();  // spike during SCAN
    spike_pushback_i = 0;
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL scan_busy got=%b exp=1", busy_o); end
    wait_result();
    total++; if (result_valid_o !== 1'b1 || result_class_o !== 4'd1 || result_count_o !== 8'd1) begin bad++; $display("FAIL scan_spike got=%b/%0d/%0d exp=1/1/1", result_valid_o, result_class_o, result_count_o); end
    fifo_rd_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      total++; if (fifo_rd_valid_o !== 1'b1 || fifo_rd_addr_o !== 8'd247) begin bad++; $display("FAIL scan_fifo idx=%0d got=%b/%0d exp=1/247", i, fifo_rd_valid_o, fifo_rd_addr_o); end
      tick();
    end
    fifo_rd_ready_i = 0;
    do_clear();
    inference_done_i = 1; tick(); inference_done_i = 0;
    tick(); tick(); tick();
    rst_i = 1; tick(); rst_i = 0;
    total++; if (busy_o !== 1'b0 || result_valid_o !== 1'b0) begin bad++; $display("FAIL rst_midscan got=%b%b exp=00", busy_o, result_valid_o); end
  endtask

  task automatic test_random();
    int ecls, ecnt, ehead;
    do_clear();
    for (int c = 0; c < 600; c++) begin
      ehead = (mq.size() > 0) ? mq[0] : 0;
      ecls  = (mphase == 2) ? mcls : 0;
      ecnt  = (mphase == 2) ? mbest : 0;
      total++; if (fifo_rd_valid_o !== (mq.size() > 0) || fifo_rd_addr_o !== 8'(ehead)) begin bad++; $display("FAIL rnd_fifo cyc=%0d got=%b/%0d exp=%b/%0d", c, fifo_rd_valid_o, fifo_rd_addr_o, mq.size() > 0, ehead); end
      total++; if (fifo_overflow_o !== movf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", c, fifo_overflow_o, movf); end
      total++; if (busy_o !== (mphase == 1) || result_valid_o !== (mphase == 2)) begin bad++; $display("FAIL rnd_state cyc=%0d got=%b%b exp=%b%b", c, busy_o, result_valid_o, mphase == 1, mphase == 2); end
      total++; if (result_class_o !== 4'(ecls) || result_count_o !== 8'(ecnt)) begin bad++; $display("FAIL rnd_result cyc=%0d got=%0d/%0d exp=%0d/%0d", c, result_class_o, result_count_o, ecls, ecnt); end
      spike_pushback_i      = ($urandom_range(0, 99) < 60);
      spike_pushback_addr_i = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(244, 255)) : 8'($urandom);
      fifo_rd_ready_i       = ($urandom_range(0, 99) < 40);
      inference_done_i      = ($urandom_range(0, 39) == 0);
      clear_i               = ($urandom_range(0, 149) == 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturate();
    test_overflow_clear();
    test_full_pushpop();
    test_done_scan_spike();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_collector.md
Name: spike_collector

Overview:
- Output-side stage directly downstream of the spike pushback/inference-done logic in tinyODIN.
- Consumes the per-cycle pushed-back spike (address + strobe) and buffers every spike address in a small FIFO for host readout.
- Keeps saturating per-class spike counters for the output-layer neurons.
- On inference done, runs a sequential argmax over the class counters and holds the winning class until the host clears it.

Parameters:
- M, 8, spike address width.
- N_CLASS, 10, number of output-class neurons.
- CLASS_BASE, 246, address of class 0; class k maps to address CLASS_BASE+k.
- CNT_W, 8, width of each class counter (saturating).
- CLS_W, 4, width of the class index (must satisfy 2^CLS_W >= N_CLASS).
- FIFO_DEPTH, 16, spike-address FIFO depth (power of two).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- spike_pushback_i  in  1  spike strobe, one spike per cycle when high.
- spike_pushback_addr_i  in  M  address of the spiking neuron.
- inference_done_i  in  1  single-cycle end-of-inference pulse.
- clear_i  in  1  start a new inference; flushes all state.
- fifo_rd_ready_i  in  1  host pops the FIFO head when high together with valid.
- fifo_rd_valid_o  out  1  FIFO not empty.
- fifo_rd_addr_o  out  M  FIFO head (first-word fall-through).
- fifo_overflow_o  out  1  sticky flag: a spike was dropped because the FIFO was full.
- busy_o  out  1  high while the argmax scan is running.
- result_valid_o  out  1  high while the state is DONE.
- result_class_o  out  CLS_W  winning class index.
- result_count_o  out  CNT_W  spike count of the winning class.

Behaviour:
- Reset (clk_i edge with rst_i high):
  - state = COLLECT; all counters = 0; FIFO empty.
  - All outputs read 0: fifo_rd_valid_o, fifo_rd_addr_o, fifo_overflow_o, busy_o, result_valid_o, result_class_o, result_count_o.
  - Reset takes priority over every other input, in every state, including mid-scan.
- clear_i (when rst_i is low): same effect as reset. It has priority over spike and done inputs in the same cycle.
- FIFO:
  - Every spike is pushed, in every state.
  - A push is accepted if the FIFO is not full, or if a pop (valid && ready) happens in the same cycle.
  - Otherwise the spike is dropped and fifo_overflow_o is set; the flag stays set until reset or clear.
  - A pushed address appears at the head one cycle later if the FIFO was empty.
  - Pop and push in the same cycle: occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width log2(FIFO_DEPTH)+1 tracks fill level.
- COLLECT:
  - A spike whose address is in [CLASS_BASE, CLASS_BASE+N_CLASS-1] increments counter[addr-CLASS_BASE].
  - Counters saturate at 2^CNT_W-1. Out-of-range addresses do not touch any counter.
  - inference_done_i moves the state to SCAN. A spike in the same cycle as done is counted before the scan.
- SCAN:
  - busy_o = 1. Lasts exactly N_CLASS cycles, with index i = 0..N_CLASS-1, one counter compared per cycle.
  - The running best is replaced only if counter[i] > best (strict), so ties resolve to the lowest index. The initial best is class 0 with count counter[0].
  - Spikes during SCAN go to the FIFO only; counters are frozen. inference_done_i is ignored.
- DONE:
  - If done is seen in cycle t, busy_o is high in cycles t+1..t+N_CLASS, and result_valid_o rises at t+N_CLASS+1.
  - result_valid_o = 1; result_class_o and result_count_o are stable until clear or reset.
  - Spikes go to the FIFO only; inference_done_i is ignored.
  - clear_i returns the state to COLLECT.
- All-zero counters: the result is class 0, count 0.

Test Plan:
- Reset, then 3 spikes at address 248, 5 at 250, 1 at 12, then done -> busy_o high for 10 cycles; result_valid_o=1 with class=4, count=5; FIFO pops 9 addresses in order, with 12 last.
- 2 spikes each at 246 and 249, then done -> tie resolves to class=0, count=2.
- 300 spikes at address 255, then done -> class=9, count=255 (saturated).
- 20 spikes at 246+k with no pop -> 16 addresses held, fifo_overflow_o=1, the last 4 dropped; then clear -> FIFO empty, flag=0, counters=0.
- Full FIFO with fifo_rd_ready_i=1 and a spike in the same cycle -> push accepted, occupancy stays 16, fifo_overflow_o stays 0.
- Spike at 247 in the done cycle is counted; a spike at 247 during SCAN is not counted but is pushed to the FIFO; rst_i asserted mid-SCAN -> busy_o=0, result_valid_o=0 next cycle.
